// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, forwarding, data-memory handshake and halt-drain controller for a 5-stage MIPS pipeline
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_if_id,
  input  logic [4:0]  rt_if_id,
  input  logic [4:0]  rs_id_ex,
  input  logic [4:0]  rt_id_ex,
  input  logic        MemRead_id_ex,
  input  logic [4:0]  dest_id_ex,
  input  logic [1:0]  Jump_id_ex,
  input  logic        branch_taken_ex,
  input  logic        RegWrite_ex_mem,
  input  logic        MemRead_ex_mem,
  input  logic        MemWrite_ex_mem,
  input  logic        halt_ex_mem,
  input  logic [4:0]  dest_ex_mem,
  input  logic        RegWrite_mem_wb,
  input  logic [4:0]  dest_mem_wb,
  input  logic        mem_ack,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        bubble_mem_wb,
  output logic        mem_req,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic [3:0] wait_cnt;
  logic [7:0] drain_cnt;
  logic run, wait_mem, ctl_haz, lu_haz;
  assign forward_a = (RegWrite_ex_mem && dest_ex_mem != 5'd0 && dest_ex_mem == rs_id_ex) ? 2'b10 :
                     (RegWrite_mem_wb && dest_mem_wb != 5'd0 && dest_mem_wb == rs_id_ex) ? 2'b01 : 2'b00;
  assign forward_b = (RegWrite_ex_mem && dest_ex_mem != 5'd0 && dest_ex_mem == rt_id_ex) ? 2'b10 :
                     (RegWrite_mem_wb && dest_mem_wb != 5'd0 && dest_mem_wb == rt_id_ex) ? 2'b01 : 2'b00;
  always_comb begin
    run = state == RUN || state == MEM_WAIT;
    mem_req = run && (MemRead_ex_mem || MemWrite_ex_mem);
    wait_mem = mem_req && !mem_ack;
    ctl_haz = Jump_id_ex != 2'b00 || branch_taken_ex;
    lu_haz = MemRead_id_ex && dest_id_ex != 5'd0 && (dest_id_ex == rs_if_id || dest_id_ex == rt_if_id);
    // wait_mem implies run, so the run-qualified terms only see a non-waiting RUN cycle
    stall_pc = wait_mem || !run || (!ctl_haz && lu_haz);
    stall_if_id = wait_mem || state == HALTED || (run && !ctl_haz && lu_haz);
    stall_id_ex = wait_mem || state == HALTED;
    stall_ex_mem = wait_mem;
    flush_if_id = !wait_mem && (state == DRAIN || (run && ctl_haz));
    flush_id_ex = !wait_mem && (state == DRAIN || (run && (ctl_haz || lu_haz)));
    bubble_mem_wb = wait_mem || state == HALTED;
    state_n = wait_mem ? MEM_WAIT :
              run ? (halt_ex_mem ? DRAIN : RUN) :
              (state == DRAIN && drain_cnt == 8'(DRAIN_CYCLES)) ? HALTED : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      drain_cnt <= '0;
      mem_err <= 1'b0;
      halted <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_mem ? wait_cnt + 4'(wait_cnt != 4'hf) : 4'd0;
      mem_err <= mem_err | (wait_mem && wait_cnt == 4'(MEM_TIMEOUT - 1));
      drain_cnt <= state == DRAIN ? drain_cnt + 8'd1 : 8'd0;
      halted <= state_n == HALTED;
      stall_count <= stall_count + 32'(stall_pc);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with a cycle-level reference model and literal spot checks
module tb_pipeline_ctrl;
  localparam int TO = 15;
  localparam int DC = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs_if_id, rt_if_id, rs_id_ex, rt_id_ex, dest_id_ex, dest_ex_mem, dest_mem_wb;
  logic MemRead_id_ex, branch_taken_ex, RegWrite_ex_mem, MemRead_ex_mem, MemWrite_ex_mem;
  logic halt_ex_mem, RegWrite_mem_wb, mem_ack;
  logic [1:0] Jump_id_ex;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex;
  logic bubble_mem_wb, mem_req, halted, mem_err;
  logic [1:0] forward_a, forward_b;
  logic [31:0] stall_count;
  logic [13:0] outs;
  int checks = 0, passed = 0;
  int m_wcnt = 0, m_drain = -1;
  bit m_err = 0, m_halted = 0, live = 0;
  logic [31:0] m_sc = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
    .rs_id_ex(rs_id_ex), .rt_id_ex(rt_id_ex), .MemRead_id_ex(MemRead_id_ex),
    .dest_id_ex(dest_id_ex), .Jump_id_ex(Jump_id_ex), .branch_taken_ex(branch_taken_ex),
    .RegWrite_ex_mem(RegWrite_ex_mem), .MemRead_ex_mem(MemRead_ex_mem),
    .MemWrite_ex_mem(MemWrite_ex_mem), .halt_ex_mem(halt_ex_mem), .dest_ex_mem(dest_ex_mem),
    .RegWrite_mem_wb(RegWrite_mem_wb), .dest_mem_wb(dest_mem_wb), .mem_ack(mem_ack),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_mem_wb(bubble_mem_wb), .mem_req(mem_req), .forward_a(forward_a),
    .forward_b(forward_b), .halted(halted), .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
                 bubble_mem_wb, mem_req, forward_a, forward_b, halted, mem_err};

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] s);
    return (RegWrite_ex_mem && dest_ex_mem != 0 && dest_ex_mem == s) ? 2'b10 :
           (RegWrite_mem_wb && dest_mem_wb != 0 && dest_mem_wb == s) ? 2'b01 : 2'b00;
  endfunction

  // Expected outputs from the rule set: memory wait > halted/drain > control hazard > load-use
  function automatic logic [13:0] exp_vec();
    bit act, req, ctl, lu;
    logic [6:0] c;
    act = !m_halted && m_drain < 0;
    req = act && (MemRead_ex_mem || MemWrite_ex_mem);
    ctl = Jump_id_ex != 0 || branch_taken_ex;
    lu = MemRead_id_ex && dest_id_ex != 0 && (dest_id_ex == rs_if_id || dest_id_ex == rt_if_id);
    if (req && !mem_ack) c = 7'b1111001;
    else if (m_halted) c = 7'b1110001;
    else if (m_drain >= 0) c = 7'b1000110;
    else if (ctl) c = 7'b0000110;
    else if (lu) c = 7'b1100010;
    else c = 7'b0;
    return {c, req, fwd(rs_id_ex), fwd(rt_id_ex), m_halted, m_err};
  endfunction

  always @(posedge clk) begin
    logic [13:0] e;
    e = exp_vec();
    if (rst) begin
      m_wcnt = 0; m_drain = -1; m_err = 0; m_halted = 0; m_sc = 0;
    end else begin
      if (e[13]) m_sc++;
      if (e[7] && !mem_ack) begin
        m_wcnt++;
        if (m_wcnt >= TO) m_err = 1;
      end else m_wcnt = 0;
      if (m_drain >= 0) begin
        m_drain++;
        if (m_drain == DC + 1) begin m_halted = 1; m_drain = -1; end
      end else if (!m_halted && !(e[7] && !mem_ack) && halt_ex_mem) m_drain = 0;
    end
  end

  always @(negedge clk) begin
    if (live && !rst) begin
      chk("cycle_outputs", 32'(outs), 32'(exp_vec()));
      chk("cycle_stall_count", stall_count, m_sc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs_if_id = 0; rt_if_id = 0; rs_id_ex = 0; rt_id_ex = 0; dest_id_ex = 0;
    dest_ex_mem = 0; dest_mem_wb = 0; MemRead_id_ex = 0; branch_taken_ex = 0;
    RegWrite_ex_mem = 0; MemRead_ex_mem = 0; MemWrite_ex_mem = 0; halt_ex_mem = 0;
    RegWrite_mem_wb = 0; mem_ack = 0; Jump_id_ex = 0;
  endtask

  initial begin
    clr();
    tick(); tick();
    rst = 0; live = 1; #2;
    chk("reset_outputs", 32'(outs), 0);
    chk("reset_count", stall_count, 0);
    MemRead_id_ex = 1; dest_id_ex = 5; rs_if_id = 5; #2;
    chk("lu_stall", {stall_pc, stall_if_id, flush_id_ex, stall_id_ex}, 4'b1110);
    tick(); clr(); #2;
    chk("lu_release", 32'(stall_pc), 0);
    chk("lu_count", stall_count, 1);
    MemRead_id_ex = 1; dest_id_ex = 0; rs_if_id = 0; #2;
    chk("lu_r0", 32'(stall_pc), 0);
    tick(); clr(); #2;
    chk("lu_r0_count", stall_count, 1);
    RegWrite_ex_mem = 1; dest_ex_mem = 8; RegWrite_mem_wb = 1; dest_mem_wb = 8;
    rs_id_ex = 8; rt_id_ex = 8; #2;
    chk("fwd_exmem", {forward_a, forward_b}, 4'b1010);
    tick(); RegWrite_ex_mem = 0; #2;
    chk("fwd_memwb", {forward_a, forward_b}, 4'b0101);
    tick(); RegWrite_ex_mem = 1; dest_ex_mem = 0; dest_mem_wb = 0; rs_id_ex = 0; rt_id_ex = 0; #2;
    chk("fwd_r0", {forward_a, forward_b}, 4'b0000);
    tick(); clr();
    MemRead_ex_mem = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("mw_stall", {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb, mem_req, flush_if_id}, 7'b1111110);
      tick();
    end
    mem_ack = 1; #2;
    chk("mw_release", {stall_pc, stall_ex_mem, bubble_mem_wb, mem_req}, 4'b0001);
    tick(); clr(); #2;
    chk("mw_count", stall_count, 4);
    chk("mw_no_err", 32'(mem_err), 0);
    Jump_id_ex = 2'b01; MemRead_id_ex = 1; dest_id_ex = 5; rs_if_id = 5; #2;
    chk("jmp_lu", {stall_pc, stall_if_id, flush_if_id, flush_id_ex}, 4'b0011);
    tick(); clr();
    MemRead_ex_mem = 1; Jump_id_ex = 2'b01; #2;
    chk("jmp_mw", {stall_pc, flush_if_id, flush_id_ex}, 3'b100);
    for (int i = 0; i < 14; i++) tick();
    #2 chk("mw_err_not_yet", 32'(mem_err), 0);
    tick(); tick(); #2;
    chk("mw_timeout", 32'(mem_err), 1);
    mem_ack = 1; tick(); clr(); #2;
    chk("err_sticky", 32'(mem_err), 1);
    chk("timeout_count", stall_count, 20);
    halt_ex_mem = 1; tick(); clr(); #2;
    chk("drain_ctl", {flush_if_id, flush_id_ex, stall_pc, stall_ex_mem, halted}, 5'b11100);
    tick(); #2 chk("drain_halted_lo1", 32'(halted), 0);
    tick(); #2 chk("drain_halted_lo2", 32'(halted), 0);
    tick(); #2 chk("halted_rise", {halted, bubble_mem_wb, stall_pc}, 3'b111);
    MemRead_ex_mem = 1; #2;
    chk("halted_no_req", 32'(mem_req), 0);
    repeat (3) tick();
    chk("halted_stays", 32'(halted), 1);
    clr(); rst = 1; tick(); rst = 0; #2;
    chk("rst_outputs", 32'(outs), 0);
    chk("rst_count", stall_count, 0);
    MemRead_ex_mem = 1; tick(); tick(); rst = 1; tick(); rst = 0; #2;
    chk("rst_in_wait", {mem_req, stall_pc, mem_err}, 3'b110);
    mem_ack = 1; #2;
    chk("rst_wait_ack", {mem_req, stall_pc}, 2'b10);
    tick(); clr(); tick(); tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the stall, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It generates the EX-stage forwarding selects and runs the data-memory request/acknowledge handshake for the instruction held in EX/MEM. It also sequences the halt drain, so that `halted` asserts only after the final instruction has retired.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: maximum number of wait cycles for `mem_ack` before `mem_err` is raised (4-bit counter).
- `DRAIN_CYCLES`, 2: number of cycles after halt detection needed for MEM/WB and WB to retire.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rs_if_id`, `rt_if_id`  in  5  source registers of the instruction in ID.
- `rs_id_ex`, `rt_id_ex`  in  5  source registers of the instruction in EX.
- `MemRead_id_ex`  in  1  instruction in EX is a load.
- `dest_id_ex`  in  5  destination register of the instruction in EX (already RegDst-resolved).
- `Jump_id_ex`  in  2  nonzero means a jump is taken in EX.
- `branch_taken_ex`  in  1  branch resolved taken in EX.
- `RegWrite_ex_mem`, `MemRead_ex_mem`, `MemWrite_ex_mem`, `halt_ex_mem`  in  1  controls of the instruction in MEM.
- `dest_ex_mem`  in  5  destination register of the instruction in MEM.
- `RegWrite_mem_wb`  in  1  write-enable of the instruction in WB.
- `dest_mem_wb`  in  5  destination register of the instruction in WB.
- `mem_ack`  in  1  data memory has completed the current access.
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem`  out  1  hold the named register.
- `flush_if_id`, `flush_id_ex`  out  1  load a NOP into the named register.
- `bubble_mem_wb`  out  1  load a NOP into MEM/WB.
- `mem_req`  out  1  data-memory access request.
- `forward_a`, `forward_b`  out  2  ALU operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- `halted`  out  1  pipeline has fully drained after a halt.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_count`  out  32  number of cycles in which `stall_pc` was high.

## Operation
States are RUN, MEM_WAIT, DRAIN and HALTED.

**Forwarding** (combinational, every state):
- `forward_a` = 10 if `RegWrite_ex_mem` and `dest_ex_mem` ≠ 0 and `dest_ex_mem` == `rs_id_ex`.
- Otherwise `forward_a` = 01 under the same test using the MEM/WB signals.
- Otherwise `forward_a` = 00.
- `forward_b` uses the same rules with `rt_id_ex`.

**Memory handshake:**
- `mem_req` = (`MemRead_ex_mem` | `MemWrite_ex_mem`) and state is RUN or MEM_WAIT.
- If `mem_req` is high and `mem_ack` is low, the controller enters or stays in MEM_WAIT. In this case:
  - `stall_pc`, `stall_if_id`, `stall_id_ex` and `stall_ex_mem` are all 1.
  - `bubble_mem_wb` is 1.
- `mem_ack` in the same cycle as `mem_req`: no stall, and the state is RUN next cycle.
- The wait counter increments each MEM_WAIT cycle and clears on `mem_ack`.
- When the counter reaches `MEM_TIMEOUT`, `mem_err` is set (sticky until reset) and the wait continues.

**Control hazard** (RUN only, no memory wait):
- `Jump_id_ex` ≠ 0 or `branch_taken_ex` causes `flush_if_id` = 1 and `flush_id_ex` = 1.
- Stalls stay 0.

**Load-use hazard** (RUN only, no memory wait, no control hazard):
- Condition: `MemRead_id_ex` and `dest_id_ex` ≠ 0 and (`dest_id_ex` == `rs_if_id` or `dest_id_ex` == `rt_if_id`).
- Response: `stall_pc` = 1, `stall_if_id` = 1, `flush_id_ex` = 1.

**Halt:**
- `halt_ex_mem` in RUN (after any memory wait has completed) moves the state to DRAIN with the drain counter at 0.
- In DRAIN:
  - `stall_pc` = 1, `flush_if_id` = 1, `flush_id_ex` = 1.
  - `stall_ex_mem` = 0, so the halt itself advances.
- After `DRAIN_CYCLES` cycles the state moves to HALTED.
- In HALTED: `halted` = 1, `stall_pc`, `stall_if_id` and `stall_id_ex` are 1, `bubble_mem_wb` = 1. The block leaves HALTED only on `rst`.

**Priority:** memory wait > halt/drain > control hazard > load-use.

**stall_count:** increments on each clock with `stall_pc` = 1, including MEM_WAIT, DRAIN and HALTED. It wraps modulo 2^32.

## Timing
- Every stall, flush, bubble, forward and `mem_req` output is combinational from the current inputs and the registered state, so it is valid in the same cycle as the hazard.
- State, the wait counter, the drain counter, `mem_err`, `halted` and `stall_count` update on `clk`.
- `rst` (synchronous) forces state RUN, both counters 0, `mem_err` = 0, `halted` = 0, `stall_count` = 0.
  - With all inputs at 0 after reset, every output is 0.
  - Reset during MEM_WAIT or DRAIN aborts the sequence; `mem_req` follows the inputs from the next cycle.
- Load-use costs exactly 1 bubble cycle: the stall drops on the next cycle, because the load has then moved to MEM.
- Memory wait lasts N cycles for `mem_ack` arriving N cycles after the request. The pipeline resumes in the `mem_ack` cycle.
- `halted` rises exactly `DRAIN_CYCLES` + 1 clocks after the clock that captured `halt_ex_mem` = 1.

## Test plan
- **Load-use:** `MemRead_id_ex` = 1, `dest_id_ex` = 5, `rs_if_id` = 5 → for exactly 1 cycle `stall_pc` = `stall_if_id` = `flush_id_ex` = 1; `stall_count` = 1. Repeat with `dest_id_ex` = 0 → no stall.
- **Forwarding:** EX/MEM and MEM/WB both write r8, `rs_id_ex` = 8 → `forward_a` = 10. Clear `RegWrite_ex_mem` → 01. `dest` = 0 → 00.
- **Memory wait:** `MemRead_ex_mem` = 1, `mem_ack` delayed 3 cycles → all four stalls plus `bubble_mem_wb` held for 3 cycles, released in the ack cycle. Hold `mem_ack` low for 16 cycles → `mem_err` = 1 and stays 1.
- **Priority:** jump plus load-use in the same cycle → flushes only, `stall_pc` = 0. Jump during a memory wait → stalls only, no flush.
- **Halt:** `halt_ex_mem` pulse → `flush_if_id` = 1 during DRAIN; `halted` = 1 three clocks later and stays until `rst`. Then `rst` → all outputs 0 and `stall_count` = 0.
